// File: rtl/buzzer_sched.sv
// buzzer_sched
//   Shares one buzzer pin among three requesters. The highest-index pending
//   request is granted when the scheduler is idle. The granted requester's
//   pattern then plays: N beeps of a square tone, each beep ON_CYC cycles
//   long, with OFF_CYC cycles of silence between beeps. A granted pattern is
//   never pre-empted by another request. Silence and idle drive the pin to 1.
//
// Ports
//   clk          in   clock
//   reset        in   asynchronous, active-low reset
//   req_i[2:0]   in   request level per requester, held until its ack
//   req_beeps_i  in   beep count, 4 bits per requester (req 0 in [3:0])
//   stop_i       in   synchronous abort of the pattern in progress
//   ack_o[2:0]   out  one-cycle one-hot grant pulse
//   done_o[2:0]  out  one-cycle one-hot completion pulse
//   busy_o       out  high from the grant cycle through the done cycle
//   out_o        out  buzzer drive
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no pattern; grant the highest pending request
// ON      | beep window, tone divider toggling out
// OFF     | silent gap between beeps, out held at 1
// DONE    | done pulse cycle; a zero-beep grant spends its ack cycle here
//         | first, with done still low
module buzzer_sched #(
    parameter int unsigned TONE0_HALF = 4096,
    parameter int unsigned TONE1_HALF = 2048,
    parameter int unsigned TONE2_HALF = 1024,
    parameter int unsigned ON_CYC     = 2000000,
    parameter int unsigned OFF_CYC    = 2000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req_i,
    input  logic [11:0] req_beeps_i,
    input  logic        stop_i,
    output logic [2:0]  ack_o,
    output logic [2:0]  done_o,
    output logic        busy_o,
    output logic        out_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ON   = 2'd1;
    localparam logic [1:0] ST_OFF  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Terminal counts: counters run 0..LAST, so LAST = length - 1.
    localparam logic [23:0] ON_LAST    = 24'(ON_CYC - 1);
    localparam logic [23:0] OFF_LAST   = 24'(OFF_CYC - 1);
    localparam logic [23:0] TONE0_LAST = 24'(TONE0_HALF - 1);
    localparam logic [23:0] TONE1_LAST = 24'(TONE1_HALF - 1);
    localparam logic [23:0] TONE2_LAST = 24'(TONE2_HALF - 1);

    logic [1:0]  state_q, state_d;
    logic [2:0]  gnt_q, gnt_d;
    logic [23:0] half_last_q, half_last_d;
    logic [3:0]  beeps_q, beeps_d;
    logic [23:0] tone_q, tone_d;
    logic [23:0] dur_q, dur_d;
    logic        out_q, out_d;
    logic        busy_q, busy_d;
    logic [2:0]  ack_q, ack_d;
    logic [2:0]  done_q, done_d;

    // Fixed priority: requester 2 wins over 1, 1 over 0.
    logic [2:0]  gnt_sel;
    logic [23:0] half_sel;
    logic [3:0]  beeps_sel;

    always_comb begin
        gnt_sel   = 3'b001;
        half_sel  = TONE0_LAST;
        beeps_sel = req_beeps_i[3:0];
        if (req_i[2]) begin
            gnt_sel   = 3'b100;
            half_sel  = TONE2_LAST;
            beeps_sel = req_beeps_i[11:8];
        end else if (req_i[1]) begin
            gnt_sel   = 3'b010;
            half_sel  = TONE1_LAST;
            beeps_sel = req_beeps_i[7:4];
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        half_last_d = half_last_q;
        beeps_d     = beeps_q;
        tone_d      = tone_q;
        dur_d       = dur_q;
        out_d       = out_q;
        busy_d      = busy_q;
        ack_d       = 3'b000;
        done_d      = 3'b000;

        case (state_q)
            ST_IDLE: begin
                if (req_i != 3'b000) begin
                    gnt_d       = gnt_sel;
                    half_last_d = half_sel;
                    beeps_d     = beeps_sel;
                    ack_d       = gnt_sel;
                    busy_d      = 1'b1;
                    tone_d      = 24'd0;
                    dur_d       = 24'd0;
                    out_d       = 1'b1;
                    state_d     = (beeps_sel != 4'd0) ? ST_ON : ST_DONE;
                end
            end

            ST_ON: begin
                if (stop_i) begin
                    out_d   = 1'b1;
                    done_d  = gnt_q;
                    state_d = ST_DONE;
                end else if (dur_q == ON_LAST) begin
                    // Window end wins over a tone toggle on the same cycle.
                    out_d   = 1'b1;
                    beeps_d = beeps_q - 4'd1;
                    dur_d   = 24'd0;
                    tone_d  = 24'd0;
                    if (beeps_q == 4'd1) begin
                        done_d  = gnt_q;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_OFF;
                    end
                end else begin
                    dur_d = dur_q + 24'd1;
                    if (tone_q == half_last_q) begin
                        out_d  = ~out_q;
                        tone_d = 24'd0;
                    end else begin
                        tone_d = tone_q + 24'd1;
                    end
                end
            end

            ST_OFF: begin
                out_d = 1'b1;
                if (stop_i) begin
                    done_d  = gnt_q;
                    state_d = ST_DONE;
                end else if (dur_q == OFF_LAST) begin
                    dur_d   = 24'd0;
                    tone_d  = 24'd0;
                    state_d = ST_ON;
                end else begin
                    dur_d = dur_q + 24'd1;
                end
            end

            default: begin
                // Arriving with done already set means the pulse is showing
                // now; otherwise this is the ack cycle of a zero-beep grant.
                if (done_q != 3'b000) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    done_d = gnt_q;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            gnt_q       <= 3'b000;
            half_last_q <= 24'd0;
            beeps_q     <= 4'd0;
            tone_q      <= 24'd0;
            dur_q       <= 24'd0;
            out_q       <= 1'b1;
            busy_q      <= 1'b0;
            ack_q       <= 3'b000;
            done_q      <= 3'b000;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            half_last_q <= half_last_d;
            beeps_q     <= beeps_d;
            tone_q      <= tone_d;
            dur_q       <= dur_d;
            out_q       <= out_d;
            busy_q      <= busy_d;
            ack_q       <= ack_d;
            done_q      <= done_d;
        end
    end

    assign ack_o  = ack_q;
    assign done_o = done_q;
    assign busy_o = busy_q;
    assign out_o  = out_q;

endmodule

// File: tb/tb_buzzer_sched.sv
// Bench for buzzer_sched. Expected waveforms come from closed-form rules:
// within a pattern, cycle c (c=0 is the ack cycle) sits at position
// r = c mod (ON+OFF); out is the parity of floor(r/HALF) while r < ON and 1
// otherwise. The done cycle index is the pattern length, or stop cycle + 1.
module tb_buzzer_sched;

    localparam int T0   = 8;
    localparam int T1   = 4;
    localparam int T2   = 3;
    localparam int ONC  = 32;
    localparam int OFFC = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req_i;
    logic [11:0] req_beeps_i;
    logic        stop_i;
    logic [2:0]  ack_o;
    logic [2:0]  done_o;
    logic        busy_o;
    logic        out_o;

    int total = 0;
    int bad   = 0;
    int last_busy = 0;

    always #5 clk = ~clk;

    buzzer_sched #(
        .TONE0_HALF(T0),
        .TONE1_HALF(T1),
        .TONE2_HALF(T2),
        .ON_CYC    (ONC),
        .OFF_CYC   (OFFC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_i      (req_i),
        .req_beeps_i(req_beeps_i),
        .stop_i     (stop_i),
        .ack_o      (ack_o),
        .done_o     (done_o),
        .busy_o     (busy_o),
        .out_o      (out_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s at %0t: got %0h want %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ack"},  ack_o,            3'b000);
        chk({tag, "_done"}, done_o,           3'b000);
        chk({tag, "_busy"}, {2'b00, busy_o},  3'b000);
        chk({tag, "_out"},  {2'b00, out_o},   3'b001);
    endtask

    function automatic logic exp_tone(input int c, input int half);
        int r;
        r = c % (ONC + OFFC);
        if (r < ONC) return ((r / half) % 2) == 0;
        return 1'b1;
    endfunction

    // Caller leaves the DUT idle with req_i != 0. stop_sel: -1 none,
    // -2 random, >= 0 assert stop during that pattern cycle.
    task automatic run_pattern(input int stop_sel);
        int g;
        int n;
        int half;
        int len;
        int d;
        int stop_at;
        int busy_n;
        logic [2:0] oh;
        logic e_out;
        g = -1;
        for (int i = 2; i >= 0; i--) if (req_i[i] && g < 0) g = i;
        n = int'(req_beeps_i[4*g +: 4]);
        half = (g == 2) ? T2 : (g == 1) ? T1 : T0;
        oh = 3'b000;
        oh[g] = 1'b1;
        len = (n == 0) ? 0 : n * ONC + (n - 1) * OFFC;
        stop_at = -1;
        if (n > 0) begin
            if (stop_sel == -2) begin
                if ($urandom_range(0, 1) == 1) stop_at = int'($urandom_range(0, len - 1));
            end else begin
                stop_at = stop_sel;
            end
        end
        d = (n == 0) ? 1 : (stop_at >= 0) ? stop_at + 1 : len;
        busy_n = 0;
        tick();
        for (int c = 0; c <= d; c++) begin
            e_out = (c < d && n > 0) ? exp_tone(c, half) : 1'b1;
            chk("ack",  ack_o,           (c == 0) ? oh : 3'b000);
            chk("done", done_o,          (c == d) ? oh : 3'b000);
            chk("busy", {2'b00, busy_o}, 3'b001);
            chk("out",  {2'b00, out_o},  {2'b00, e_out});
            if (busy_o === 1'b1) busy_n++;
            if (c == 0) req_i[g] = 1'b0;
            stop_i = (c == stop_at);
            tick();
        end
        stop_i = 1'b0;
        chk_idle("post");
        last_busy = busy_n;
    endtask

    initial begin
        reset       = 1'b0;
        req_i       = 3'b111;
        req_beeps_i = 12'h000;
        stop_i      = 1'b0;

        // Reset held with every request high.
        repeat (5) begin
            tick();
            chk_idle("rst");
        end
        reset = 1'b1;

        // First grant after release goes to requester 2; all three have zero
        // beeps, so each is an ack cycle then a done cycle.
        run_pattern(-1);
        run_pattern(-1);
        run_pattern(-1);

        // Two-beep pattern on requester 0.
        req_beeps_i = 12'h002;
        req_i       = 3'b001;
        run_pattern(-1);
        total++;
        assert (last_busy == 2 * ONC + OFFC + 1) else begin
            bad++;
            $error("FAIL busy_len: got %0d want %0d", last_busy, 2 * ONC + OFFC + 1);
        end

        // Arbitration: all three request one beep at once.
        req_beeps_i = 12'h111;
        req_i       = 3'b111;
        run_pattern(-1);
        run_pattern(-1);
        run_pattern(-1);

        // Stop 10 cycles into the second beep of a three-beep pattern.
        req_beeps_i = 12'h003;
        req_i       = 3'b001;
        run_pattern(ONC + OFFC + 10);
        repeat (5) begin
            tick();
            chk_idle("after_stop");
        end

        // Randomised request mixes, beep counts and stop points.
        repeat (6) begin
            req_beeps_i = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                           4'($urandom_range(0, 3))};
            req_i = 3'($urandom_range(1, 7));
            while (req_i != 3'b000) run_pattern(-2);
        end

        // Reset asserted during an OFF gap.
        req_beeps_i = 12'h002;
        req_i       = 3'b001;
        tick();
        chk("moff_ack", ack_o, 3'b001);
        req_i = 3'b000;
        repeat (ONC + 4) tick();
        chk("moff_busy", {2'b00, busy_o}, 3'b001);
        chk("moff_out",  {2'b00, out_o},  3'b001);
        reset = 1'b0;
        #1;
        chk_idle("rst_async");
        repeat (3) begin
            tick();
            chk_idle("rst_hold");
        end
        reset = 1'b1;
        repeat (4) begin
            tick();
            chk_idle("rel_idle");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
